// File: rtl/ram_pkg.sv
// Shared types and constants for the scratch-RAM request controller.
package ram_pkg;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 4;
  localparam int DEPTH  = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    CAPT  = 2'd2,
    RESP  = 2'd3
  } ram_ctrl_state_t;

  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr);
    return (addr < ADDR_W'(DEPTH));
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: counts inc pulses and sticks at all-ones.
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // next count: step only while below the ceiling
  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + CNT_W'(1);
    end else begin
      count_d = count_q;
    end
  end

  // count register
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= {CNT_W{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/ram_req_ctrl.sv
// Single-outstanding request sequencer driving the 4-entry scratch RAM pins,
// returning one response per request and tracking saturating activity counts.
module ram_req_ctrl
  import ram_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_write,
  output logic              rsp_err,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              ce_mem,
  output logic              we_mem,
  output logic [ADDR_W-1:0] addr_mem,
  output logic [DATA_W-1:0] datai_mem,
  input  logic [DATA_W-1:0] datao_mem,
  output logic [CNT_W-1:0]  wr_cnt,
  output logic [CNT_W-1:0]  rd_cnt,
  output logic [CNT_W-1:0]  err_cnt
);

  ram_ctrl_state_t state_q, state_d;
  req_t            req_q, req_d;
  req_t            in_req_s;

  logic              ce_mem_q, ce_mem_d;
  logic              we_mem_q, we_mem_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_write_q, rsp_write_d;
  logic              rsp_err_q, rsp_err_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

  logic accept_s;
  logic in_range_s;
  logic rsp_hs_s;
  logic inc_wr_s;
  logic inc_rd_s;
  logic inc_err_s;

  assign in_req_s   = {req_write, req_addr, req_wdata};
  assign accept_s   = req_valid && (state_q == IDLE);
  assign in_range_s = addr_in_range(req_addr);
  assign rsp_hs_s   = rsp_valid_q && rsp_ready;

  // next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          state_d = in_range_s ? ISSUE : RESP;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE:   state_d = req_q.write ? RESP : CAPT;
      CAPT:    state_d = RESP;
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end else begin
          state_d = RESP;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The latched request feeds the RAM address/data pins directly, so it only
  // updates when a strobe will follow; rejected requests leave the pins alone.
  always_comb begin
    if (accept_s && in_range_s) begin
      req_d = in_req_s;
    end else begin
      req_d = req_q;
    end
  end

  // registered-output next values
  always_comb begin
    ce_mem_d    = 1'b0;
    we_mem_d    = 1'b0;
    rsp_valid_d = (state_d == RESP);
    rsp_write_d = rsp_write_q;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;
    case (state_q)
      IDLE: begin
        if (accept_s && in_range_s) begin
          ce_mem_d    = 1'b1;
          we_mem_d    = req_write;
          rsp_write_d = req_write;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = {DATA_W{1'b0}};
        end else if (accept_s) begin
          rsp_write_d = req_write;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = {DATA_W{1'b0}};
        end else begin
          ce_mem_d = 1'b0;
          we_mem_d = 1'b0;
        end
      end
      ISSUE:   ce_mem_d    = 1'b0;
      CAPT:    rsp_rdata_d = datao_mem;
      RESP:    ce_mem_d    = 1'b0;
      default: ce_mem_d    = 1'b0;
    endcase
  end

  // state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // output and request registers
  always_ff @(posedge clk) begin
    if (rst) begin
      req_q       <= '{write: 1'b0, addr: {ADDR_W{1'b0}}, wdata: {DATA_W{1'b0}}};
      ce_mem_q    <= 1'b0;
      we_mem_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= {DATA_W{1'b0}};
    end else begin
      req_q       <= req_d;
      ce_mem_q    <= ce_mem_d;
      we_mem_q    <= we_mem_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_write_q <= rsp_write_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign inc_wr_s  = rsp_hs_s && rsp_write_q && !rsp_err_q;
  assign inc_rd_s  = rsp_hs_s && !rsp_write_q && !rsp_err_q;
  assign inc_err_s = rsp_hs_s && rsp_err_q;

  sat_counter #(.CNT_W(CNT_W)) u_wr_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (inc_wr_s),
    .count (wr_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_rd_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (inc_rd_s),
    .count (rd_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_err_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (inc_err_s),
    .count (err_cnt)
  );

  assign req_ready = (state_q == IDLE);
  assign ce_mem    = ce_mem_q;
  assign we_mem    = we_mem_q;
  assign addr_mem  = req_q.addr;
  assign datai_mem = req_q.wdata;
  assign rsp_valid = rsp_valid_q;
  assign rsp_write = rsp_write_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_ram_req_ctrl.sv
// Scoreboard bench for ram_req_ctrl: a reference model queues expected
// responses at accept time, a negedge monitor checks them as they appear.
module tb_ram_req_ctrl;

  localparam int CW  = 8;
  localparam int SAT = 255;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic          req_write;
  logic [3:0]    req_addr;
  logic [3:0]    req_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic          rsp_write;
  logic          rsp_err;
  logic [3:0]    rsp_rdata;
  logic          ce_mem;
  logic          we_mem;
  logic [3:0]    addr_mem;
  logic [3:0]    datai_mem;
  logic [3:0]    datao_mem;
  logic [CW-1:0] wr_cnt;
  logic [CW-1:0] rd_cnt;
  logic [CW-1:0] err_cnt;

  ram_req_ctrl #(.CNT_W(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_write (rsp_write),
    .rsp_err   (rsp_err),
    .rsp_rdata (rsp_rdata),
    .ce_mem    (ce_mem),
    .we_mem    (we_mem),
    .addr_mem  (addr_mem),
    .datai_mem (datai_mem),
    .datao_mem (datao_mem),
    .wr_cnt    (wr_cnt),
    .rd_cnt    (rd_cnt),
    .err_cnt   (err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       write;
    logic       err;
    logic [3:0] addr;
    logic [3:0] wdata;
    logic [3:0] rdata;
    int         exp_cyc;
    bit         seen;
    bit         late;
  } exp_t;

  exp_t       exp_q[$];
  logic [3:0] model_mem [0:3];
  logic [3:0] ram [0:3];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ce_seen = 0;
  int ce_exp = 0;
  int last_hs_cyc = -100;
  int m_wr = 0;
  int m_rd = 0;
  int m_err = 0;
  bit chk_cnt = 1'b0;
  logic prev_ce = 1'b0;
  int ready_mode = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // RAM with registered read data
  always @(posedge clk) begin
    if (ce_mem === 1'b1) begin
      if (we_mem) ram[addr_mem[1:0]] <= datai_mem;
      else        datao_mem <= ram[addr_mem[1:0]];
    end
  end

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       rsp_ready = 1'b1;
      1:       rsp_ready = ($urandom_range(0, 3) != 0);
      default: rsp_ready = 1'b0;
    endcase
  end

  // monitor / scoreboard
  always @(negedge clk) begin
    exp_t e;
    if (ce_mem === 1'b1) ce_seen++;
    if (rst) begin
      m_wr = 0; m_rd = 0; m_err = 0; chk_cnt = 1'b0; prev_ce = 1'b0;
    end else begin
      if (chk_cnt) begin
        check("wr_cnt", 32'(wr_cnt), 32'(m_wr));
        check("rd_cnt", 32'(rd_cnt), 32'(m_rd));
        check("err_cnt", 32'(err_cnt), 32'(m_err));
        chk_cnt = 1'b0;
      end
      if (!ce_mem) check("we_without_ce", 32'(we_mem), 32'd0);
      if (ce_mem) begin
        check("ce_single_cycle", 32'(prev_ce), 32'd0);
        if (exp_q.size() == 0) fail_now("ce_spurious");
        else begin
          e = exp_q[0];
          check("ce_on_error", 32'(e.err), 32'd0);
          if (e.write) check("mem_pins_wr", 32'({we_mem, addr_mem, datai_mem}), 32'({1'b1, e.addr, e.wdata}));
          else         check("mem_pins_rd", 32'({we_mem, addr_mem}), 32'({1'b0, e.addr}));
        end
      end
      prev_ce = ce_mem;
      if (rsp_valid) begin
        check("req_ready_busy", 32'(req_ready), 32'd0);
        if (exp_q.size() == 0) fail_now("rsp_spurious");
        else begin
          e = exp_q.pop_front();
          if (!e.seen) begin
            check("rsp_latency", 32'(cyc), 32'(e.exp_cyc));
            e.seen = 1'b1;
          end
          check("rsp_write", 32'(rsp_write), 32'(e.write));
          check("rsp_err", 32'(rsp_err), 32'(e.err));
          check("rsp_rdata", 32'(rsp_rdata), 32'(e.rdata));
          if (rsp_ready) begin
            if (e.err)        begin if (m_err < SAT) m_err++; end
            else if (e.write) begin if (m_wr < SAT) m_wr++; end
            else              begin if (m_rd < SAT) m_rd++; end
            chk_cnt = 1'b1;
            last_hs_cyc = cyc;
          end else begin
            exp_q.push_front(e);
          end
        end
      end else if (exp_q.size() != 0) begin
        e = exp_q[0];
        if (!e.late && cyc > e.exp_cyc) begin
          fail_now("rsp_late");
          e = exp_q.pop_front();
          e.late = 1'b1;
          exp_q.push_front(e);
        end
      end
    end
  end

  task automatic issue(input logic w, input logic [3:0] a, input logic [3:0] d, output int acc_k);
    exp_t e;
    int n;
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
    acc_k = -1;
    n = 0;
    while (acc_k < 0 && n < 200) begin
      @(negedge clk);
      if (req_ready) begin
        acc_k = cyc;
        e.write = w; e.addr = a; e.wdata = d; e.err = (a >= 4'd4);
        e.seen = 1'b0; e.late = 1'b0;
        if (e.err) begin
          e.rdata = 4'd0; e.exp_cyc = cyc + 1;
        end else if (w) begin
          model_mem[a[1:0]] = d; e.rdata = 4'd0; e.exp_cyc = cyc + 2; ce_exp++;
        end else begin
          e.rdata = model_mem[a[1:0]]; e.exp_cyc = cyc + 3; ce_exp++;
        end
        exp_q.push_back(e);
      end else begin
        n++;
      end
    end
    if (acc_k < 0) fail_now("accept_timeout");
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      fail_now("drain_timeout");
      exp_q.delete();
    end
    @(posedge clk); #1;
  endtask

  initial begin
    int k;
    int n;
    int gap;
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = 4'd0; req_wdata = 4'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_req_ready", 32'(req_ready), 32'd1);
    check("reset_rsp", 32'({rsp_valid, rsp_write, rsp_err, rsp_rdata}), 32'd0);
    check("reset_mem", 32'({ce_mem, we_mem, addr_mem, datai_mem}), 32'd0);
    check("reset_cnt", 32'({wr_cnt, rd_cnt, err_cnt}), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    issue(1'b1, 4'd2, 4'hA, k);
    issue(1'b0, 4'd2, 4'h0, k);
    drain();
    @(negedge clk);
    check("dir_wr_cnt", 32'(wr_cnt), 32'd1);
    check("dir_rd_cnt", 32'(rd_cnt), 32'd1);
    @(posedge clk); #1;

    issue(1'b0, 4'h7, 4'h0, k);
    drain();
    @(negedge clk);
    check("dir_err_cnt", 32'(err_cnt), 32'd1);
    @(posedge clk); #1;

    ready_mode = 2;
    @(posedge clk); #1;
    issue(1'b0, 4'd2, 4'h0, k);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 4'd1; req_wdata = 4'd5;
    n = 0;
    while (!rsp_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("hold_rsp_arrived", 32'(rsp_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_req_ready", 32'(req_ready), 32'd0);
      check("hold_rsp_valid", 32'(rsp_valid), 32'd1);
    end
    ready_mode = 0;
    issue(1'b1, 4'd1, 4'd5, k);
    check("accept_after_hs", 32'(k), 32'(last_hs_cyc + 1));
    drain();

    issue(1'b1, 4'd3, 4'h6, k);
    check("rst_test_in_issue", 32'(ce_mem), 32'd1);
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_ce", 32'({ce_mem, we_mem}), 32'd0);
    check("rst_mid_req_ready", 32'(req_ready), 32'd1);
    check("rst_mid_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_mid_cnt", 32'({wr_cnt, rd_cnt, err_cnt}), 32'd0);
    @(posedge clk); #1;

    for (int a = 0; a < 4; a++) issue(1'b1, 4'(a), 4'($urandom_range(0, 15)), k);
    for (int a = 0; a < 4; a++) issue(1'b0, 4'(a), 4'h0, k);
    drain();
    @(negedge clk);
    check("b2b_wr_cnt", 32'(wr_cnt), 32'd4);
    check("b2b_rd_cnt", 32'(rd_cnt), 32'd4);
    @(posedge clk); #1;

    ready_mode = 1;
    for (int t = 0; t < 1500; t++) begin
      gap = $urandom_range(0, 2);
      repeat (gap) begin
        @(posedge clk); #1;
      end
      issue(1'($urandom_range(0, 1)), 4'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), k);
    end
    ready_mode = 0;
    drain();
    @(negedge clk);
    check("sat_wr_cnt", 32'(wr_cnt), 32'(SAT));
    check("sat_rd_cnt", 32'(rd_cnt), 32'(SAT));
    check("sat_err_cnt", 32'(err_cnt), 32'(SAT));
    check("ce_pulse_total", 32'(ce_seen), 32'(ce_exp));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
